// File: rtl/reset_seq.sv
// Staged reset sequencer: stretches the synchronized reset, then releases each
// domain in index order, waiting for its ack (bounded by a timeout) before the next.
//
// state   | meaning
// ASSERT  | all domains held in reset, counting out the stretch period
// RELEASE | stage idx released, waiting for GAP and its ack (or the timeout)
// RUN     | every domain released; acks ignored until soft_req
module reset_seq #(
  parameter int NUM_STAGES = 3,
  parameter int STRETCH    = 16,
  parameter int GAP        = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  soft_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int MAXC = (STRETCH > TIMEOUT) ? STRETCH : TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(NUM_STAGES) + 1;

  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP - 1);
  localparam logic [CW-1:0] TO_LAST      = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TO_SAT       = CW'(TIMEOUT);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic            ack_cur;

  // Mux the ack of the stage currently being released.
  always_comb begin
    ack_cur = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (idx == IW'(i)) ack_cur = stage_ack[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ASSERT;
      cnt         <= '0;
      idx         <= '0;
      rst_n_out   <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ASSERT: begin
          if (cnt == STRETCH_LAST) begin
            rst_n_out <= NUM_STAGES'(1);
            cnt       <= '0;
            idx       <= '0;
            state     <= RELEASE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (soft_req) begin
            rst_n_out <= '0;
            cnt       <= '0;
            idx       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= ASSERT;
          end else if (cnt == TO_LAST || (cnt >= GAP_LAST && ack_cur)) begin
            // The timeout path wins even when the ack lands on the same edge.
            if (cnt == TO_LAST) timeout_err <= 1'b1;
            if (idx == IDX_LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= RUN;
            end else begin
              rst_n_out <= (rst_n_out << 1) | NUM_STAGES'(1);
              idx       <= idx + IW'(1);
              cnt       <= '0;
            end
          end else if (cnt != TO_SAT) begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          if (soft_req) begin
            rst_n_out <= '0;
            cnt       <= '0;
            idx       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= ASSERT;
          end else begin
            rst_n_out <= '1;
          end
        end
        default: begin
          rst_n_out <= '0;
          cnt       <= '0;
          idx       <= '0;
          busy      <= 1'b1;
          done      <= 1'b0;
          state     <= ASSERT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: expected output events come from an
// edge-timing model of the release schedule; a monitor checks every output change.
module tb_reset_seq;

  localparam int N       = 3;
  localparam int STRETCH = 16;
  localparam int GAP     = 8;
  localparam int TIMEOUT = 64;
  localparam int NEVER   = 255;
  localparam int FAR     = 1 << 30;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         soft_req = 1'b0;
  logic [N-1:0] stage_ack = '0;
  logic [N-1:0] rst_n_out;
  logic         busy, done, timeout_err;

  reset_seq #(.NUM_STAGES(N), .STRETCH(STRETCH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .soft_req(soft_req), .stage_ack(stage_ack),
    .rst_n_out(rst_n_out), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           e;
    logic [N+2:0] s;
  } exp_t;

  exp_t         exp_q[$];
  int           tests = 0;
  int           fails = 0;
  int           edge_n = 0;
  int           ack_dly[N];
  int           rel_cnt[N];
  logic [N+2:0] prev;
  logic [N+2:0] cur;

  localparam logic [N+2:0] RST_SNAP = {{N{1'b0}}, 3'b100};

  function automatic logic [N+2:0] snap();
    return {rst_n_out, busy, done, timeout_err};
  endfunction

  function automatic void push(int e, logic [N-1:0] r, logic b, logic d, logic er);
    exp_t x;
    x.e = e;
    x.s = {r, b, d, er};
    exp_q.push_back(x);
  endfunction

  task automatic check(input string nm, input logic [N+2:0] got, input logic [N+2:0] want,
                       input int ge, input int we);
    tests++;
    if (got !== want || ge != we) begin
      fails++;
      $display("FAIL %s: got rst/busy/done/err=%b at edge %0d, want %b at edge %0d",
               nm, got, ge, want, we);
    end
  endtask

  // One reset sequence starting at edge s; events at or after lim are cut off.
  task automatic seg(input int s, input int lim, inout logic er, output int last_e);
    int r, t, w;
    logic [N-1:0] ro;
    last_e = s;
    r = s + STRETCH;
    if (r >= lim) return;
    ro = '0;
    ro[0] = 1'b1;
    push(r, ro, 1'b1, 1'b0, er);
    last_e = r;
    for (int i = 0; i < N; i++) begin
      if (ack_dly[i] >= TIMEOUT) w = TIMEOUT;
      else w = (ack_dly[i] > GAP) ? ack_dly[i] : GAP;
      t = r + w;
      if (t >= lim) return;
      if (ack_dly[i] >= TIMEOUT) er = 1'b1;
      if (i < N - 1) begin
        ro[i+1] = 1'b1;
        push(t, ro, 1'b1, 1'b0, er);
      end else begin
        push(t, ro, 1'b0, 1'b1, er);
      end
      last_e = t;
      r = t;
    end
  endtask

  // Ack driver: stage i's ack is seen high from ack_dly[i] edges after its release.
  initial begin
    for (int i = 0; i < N; i++) rel_cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!rst_n_out[i]) begin
          rel_cnt[i]   = 0;
          stage_ack[i] = 1'b0;
        end else begin
          rel_cnt[i]++;
          stage_ack[i] = (rel_cnt[i] >= ack_dly[i]);
        end
      end
    end
  end

  // Monitor: every output change must match the next expected event.
  initial begin
    exp_t x;
    prev = RST_SNAP;
    forever begin
      @(posedge clk);
      #1;
      cur = snap();
      if (!reset) begin
        edge_n = 0;
        prev   = cur;
      end else begin
        edge_n++;
        if (cur !== prev) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_change: got %b at edge %0d, want no change", cur, edge_n);
          end else begin
            x = exp_q.pop_front();
            check("out_event", cur, x.s, edge_n, x.e);
          end
          prev = cur;
        end
      end
    end
  end

  task automatic run_scn(input int soft_e, input int abort_e);
    logic er;
    int   last;
    @(negedge clk);
    reset    = 1'b0;
    soft_req = 1'b0;
    #1;
    check("reset_state", snap(), RST_SNAP, 0, 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    er = 1'b0;
    if (soft_e > STRETCH) begin
      seg(0, soft_e, er, last);
      push(soft_e, '0, 1'b1, 1'b0, er);
      seg(soft_e, FAR, er, last);
    end else begin
      seg(0, FAR, er, last);
    end
    reset = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (abort_e > 0 && edge_n == abort_e) begin
        soft_req = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_reset", snap(), RST_SNAP, 0, 0);
        exp_q.delete();
        return;
      end
      if (edge_n >= last + 5) break;
      soft_req = (soft_e > 0 && edge_n == soft_e - 1);
      @(negedge clk);
    end
    soft_req = 1'b0;
    tests++;
    if (edge_n < last + 5) begin
      fails++;
      $display("FAIL seq_budget: reached edge %0d, want edge %0d", edge_n, last + 5);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_events: %0d left, next want %b at edge %0d",
               exp_q.size(), exp_q[0].s, exp_q[0].e);
    end
  endtask

  initial begin
    int mode, soft_e, abort_e;
    ack_dly = '{1, 1, 1};     run_scn(0, 0);
    ack_dly = '{1, 20, 1};    run_scn(0, 0);
    ack_dly = '{NEVER, 1, 1}; run_scn(100, 0);
    ack_dly = '{1, 1, 1};     run_scn(5, 0);
    run_scn(24, 0);
    run_scn(45, 0);
    ack_dly = '{NEVER, 1, 1}; run_scn(0, 90);
    ack_dly = '{1, 1, 1};     run_scn(0, 30);
    for (int s = 0; s < 30; s++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0:       ack_dly[i] = $urandom_range(1, GAP);
          1:       ack_dly[i] = $urandom_range(GAP, TIMEOUT - 1);
          2:       ack_dly[i] = $urandom_range(TIMEOUT, TIMEOUT + 2);
          default: ack_dly[i] = NEVER;
        endcase
      end
      mode = $urandom_range(0, 2);
      if (mode == 0) soft_e = 0;
      else if (mode == 1) soft_e = $urandom_range(1, STRETCH);
      else soft_e = $urandom_range(STRETCH + 1, STRETCH + N * TIMEOUT + 10);
      abort_e = ($urandom_range(0, 5) == 0) ? $urandom_range(STRETCH + 1, STRETCH + 40) : 0;
      run_scn(soft_e, abort_e);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
